// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin sharing of one 8-bit SPI transmit engine.
// Grants a requester, pulses the engine start, then reports done or timeout.
module spi_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic                 spi_tx_enable,
    output logic [7:0]           spi_tx_data,
    input  logic                 spi_busy,
    output logic [NUM_REQ-1:0]   dev_sel,
    output logic [2:0]           grant_id
);

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST =
        4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [2:0]         r_ptr;
    logic [TW-1:0]      r_tcnt;
    logic [3:0]         r_gcnt;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_err;
    logic               r_en;
    logic [7:0]         r_data;
    logic [NUM_REQ-1:0] r_sel;
    logic [2:0]         r_gid;

    logic               w_any;
    logic [2:0]         w_pick;
    logic [2:0]         w_next;
    logic [NUM_REQ-1:0] w_sel;
    logic [7:0]         w_byte;
    logic               w_gap_end;
    int                 w_dist;
    int                 w_best;

    // Pick the requester closest to the pointer, searching upward with wrap.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_next = '0;
        w_sel  = '0;
        w_byte = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i >= int'(r_ptr)) begin
                w_dist = i - int'(r_ptr);
            end else begin
                w_dist = i - int'(r_ptr) + NUM_REQ;
            end
            if (req[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_any    = 1'b1;
                w_pick   = 3'(i);
                w_sel    = '0;
                w_sel[i] = 1'b1;
                w_byte   = req_data[8*i +: 8];
                w_next   = (i == NUM_REQ - 1) ? 3'd0 : 3'(i + 1);
            end
        end
    end

    // A zero-length gap still spends one cycle in GAP before idling.
    always_comb begin
        w_gap_end = (GAP_CYCLES == 0) || (r_gcnt == GAP_LAST);
    end

    // Transfer sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_tcnt  <= '0;
            r_gcnt  <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_en    <= 1'b0;
            r_data  <= 8'h00;
            r_sel   <= '0;
            r_gid   <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_err  <= '0;
            r_en   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ack   <= w_sel;
                        r_sel   <= w_sel;
                        r_gid   <= w_pick;
                        r_data  <= w_byte;
                        r_ptr   <= w_next;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_en    <= 1'b1;
                    r_tcnt  <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (spi_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_tcnt == TO_LAST) begin
                        r_err   <= r_sel;
                        r_sel   <= '0;
                        r_gcnt  <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!spi_busy) begin
                        r_done  <= r_sel;
                        r_sel   <= '0;
                        r_gcnt  <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack           = r_ack;
    assign done          = r_done;
    assign err           = r_err;
    assign spi_tx_enable = r_en;
    assign spi_tx_data   = r_data;
    assign dev_sel       = r_sel;
    assign grant_id      = r_gid;

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 8-bit SPI transmit engine between NUM_REQ requesters.
- Accepts a byte from the winning requester, drives a one-cycle start pulse and the byte into the engine, and steers the one-hot device select.
- Tracks the engine's busy flag through the transfer, then reports completion (or timeout) to the owner.
- Sits between the client logic and the SPI transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, idle clocks forced between consecutive transfers (0..15).
- START_TIMEOUT, 8, clocks allowed for spi_busy to rise after the start pulse.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester transfer request; level, held until ack.
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle pulse: requester's byte latched.
- done  output  NUM_REQ  one-cycle pulse: owner's transfer completed.
- err  output  NUM_REQ  one-cycle pulse: owner's transfer aborted on timeout.
- spi_tx_enable  output  1  one-cycle start pulse to the SPI engine.
- spi_tx_data  output  8  latched byte to the SPI engine.
- spi_busy  input  1  high while the engine is shifting.
- dev_sel  output  NUM_REQ  one-hot device select of the current owner; all zero when idle.
- grant_id  output  3  index of the current or last owner.

Behaviour:
- All outputs are registered, Moore style.
- Reset (rst=0) takes effect immediately, including mid-transfer. State=IDLE; ack, done, err, spi_tx_enable, dev_sel = 0; spi_tx_data=8'h00; grant_id=0; rr pointer=0 (requester 0 highest priority); counters=0.
- IDLE:
  - If any req bit is high, pick the first set bit searching from the pointer upward with wrap.
  - On the next edge: latch spi_tx_data, set grant_id and dev_sel, pulse ack[i] for one cycle, go to START.
  - Pointer becomes (i+1) mod NUM_REQ.
- START:
  - spi_tx_enable=1 for exactly one cycle.
  - Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - If spi_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the count reaches START_TIMEOUT, pulse err[i], clear dev_sel, go to GAP.
- WAIT_DONE:
  - Stay while spi_busy=1.
  - On spi_busy=0, pulse done[i], clear dev_sel, go to GAP.
- GAP:
  - Count GAP_CYCLES clocks, then go to IDLE.
  - With GAP_CYCLES=0, go to IDLE on the next edge.
- Latency from req seen in IDLE to the ack pulse: 1 clock. The spi_tx_enable pulse follows in the cycle after ack.
- dev_sel:
  - Held constant from the ack cycle through the last spi_busy=1 cycle.
  - Never changes while spi_busy=1.
  - Never has more than one bit set.
- req bits that rise or fall outside IDLE are ignored until the next IDLE evaluation. Dropping req after ack has no effect on the transfer.
- Simultaneous requests are resolved by the rr pointer. A continuously requesting client waits at most NUM_REQ-1 transfers.
- spi_busy already high on entry to WAIT_BUSY counts as the rise.
- A spurious spi_busy outside the WAIT states is ignored.
- req_data is sampled only on the grant edge. Later changes do not affect spi_tx_data.
- done and err for the same transfer are mutually exclusive. Each transfer produces exactly one of them.
- grant_id holds its value after completion until the next grant.

Test Plan:
- Reset, then req=4'b0001 with req_data[7:0]=8'hA5:
  - Response: ack[0] pulse 1 clk later, spi_tx_enable pulse next clk with spi_tx_data=A5, dev_sel=0001.
  - Bench model holds busy for 80 clks; done[0] pulses after busy falls; dev_sel=0.
- req=4'b1111 held, bytes 11/22/33/44:
  - Response: grant order 0,1,2,3,0.
  - Gap of ≥2 idle clks between the busy fall and the next ack each time.
- Model never raises busy, req=4'b0100:
  - Response: err[2] pulse 8 clks after the start pulse, no done.
  - Next request is served normally.
- rst driven low while in WAIT_DONE (busy=1):
  - Response: all outputs 0 asynchronously.
  - After release, req=4'b0010 is granted first only if requester 0 is idle; pointer=0 restored.
- Requester 1 drops req and changes req_data from C3 to FF after its ack:
  - Response: spi_tx_data stays C3, done[1] still pulses.
- req[3] rises during requester 0's WAIT_DONE while req[1] is also pending:
  - Response: requester 1 is granted before requester 3.
  - dev_sel=0001 is unchanged until busy falls.
